ahb_slave_mem: RTL and testbench

AHB_SLAVE_MEM -- requirements
Module: ahb_slave_mem

---
 rtl/ahb_pkg.sv | 21 ++
 rtl/ahb_byte_lane_dec.sv | 21 ++
 rtl/ahb_slave_mem.sv | 78 +++++++
 tb/tb_ahb_slave_mem.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/ahb_pkg.sv
// ahb_pkg: AHB-lite bus encodings and the memory slave's FSM states.
package ahb_pkg;
    typedef enum logic [1:0] {
        HT_IDLE   = 2'b00,
        HT_BUSY   = 2'b01,
        HT_NONSEQ = 2'b10,
        HT_SEQ    = 2'b11
    } htrans_t;
    typedef enum logic [1:0] {
        HR_OKAY  = 2'b00,
        HR_ERROR = 2'b01,
        HR_RETRY = 2'b10,
        HR_SPLIT = 2'b11
    } hresp_t;
    typedef enum logic [2:0] {
        HS_BYTE, HS_HALF, HS_WORD, HS_DWORD, HS_4W, HS_8W, HS_16W, HS_32W
    } hsize_t;
    typedef enum logic [1:0] {
        ST_IDLE, ST_DATA, ST_ERR1, ST_ERR2
    } state_t;
endpackage

// File: rtl/ahb_byte_lane_dec.sv
// ahb_byte_lane_dec: byte-lane enables and alignment flag for one AHB transfer.
module ahb_byte_lane_dec #(
    parameter int DATA_W = 32,
    localparam int NB = DATA_W / 8,
    localparam int LB = $clog2(NB)
) (
    input  logic [2:0]    hsize,
    input  logic [LB-1:0] addr,
    output logic [NB-1:0] be,
    output logic          misaligned
);
    always_comb begin
        be = '0;
        misaligned = 1'b0;
        if (hsize <= 3'(LB)) begin
            // a lane is enabled when it shares the addressed 2^hsize-byte block
            for (int i = 0; i < NB; i++) be[i] = (i >> hsize) == (int'(addr) >> hsize);
            misaligned = |(addr & LB'((1 << hsize) - 1));
        end
    end
endmodule

// File: rtl/ahb_slave_mem.sv
// ahb_slave_mem: AHB-lite memory slave with programmable OKAY wait states
// and a two-cycle ERROR response for out-of-range, oversized or misaligned transfers.
module ahb_slave_mem
    import ahb_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 256,
    parameter int ADDR_W      = 32,
    parameter int WAIT_STATES = 0
) (
    input  logic              hclk,
    input  logic              reset,
    input  logic              hsel,
    input  logic [ADDR_W-1:0] haddr,
    input  logic [1:0]        htrans,
    input  logic              hwrite,
    input  logic [2:0]        hsize,
    input  logic [DATA_W-1:0] hwdata,
    input  logic              hready,
    output logic              hreadyout,
    output logic [1:0]        hresp,
    output logic [DATA_W-1:0] hrdata
);
    localparam int NB = DATA_W / 8;
    localparam int LB = $clog2(NB);
    localparam int IW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    state_t            state, state_n;
    logic [2:0]        cnt, cnt_n;
    logic [IW-1:0]     idx;
    logic [NB-1:0]     be, be_q;
    logic              wr, misaligned, accept, err, last, free;

    ahb_byte_lane_dec #(.DATA_W(DATA_W)) u_dec (
        .hsize(hsize),
        .addr(haddr[LB-1:0]),
        .be(be),
        .misaligned(misaligned)
    );

    always_comb begin
        last = state == ST_DATA && cnt == 3'd0;
        free = state == ST_IDLE || state == ST_ERR2 || last;
        accept = hsel && hready && free && (htrans_t'(htrans) inside {HT_NONSEQ, HT_SEQ});
        err = (haddr >> LB) >= ADDR_W'(DEPTH) || hsize > 3'(LB) || misaligned;
        state_n = state == ST_ERR1 ? ST_ERR2 : !free ? ST_DATA : !accept ? ST_IDLE : err ? ST_ERR1 : ST_DATA;
        cnt_n = accept && !err ? 3'(WAIT_STATES) : !free && state == ST_DATA ? cnt - 3'd1 : 3'd0;
        // outputs are forced to their idle values for the whole reset cycle
        hreadyout = reset || free;
        hresp = !reset && (state == ST_ERR1 || state == ST_ERR2) ? HR_ERROR : HR_OKAY;
        hrdata = !reset && state == ST_DATA && !wr ? mem[idx] : '0;
    end

    always_ff @(posedge hclk) begin
        if (reset) begin
            state <= ST_IDLE;
            cnt <= 3'd0;
        end else begin
            state <= state_n;
            cnt <= cnt_n;
        end
    end

    always_ff @(posedge hclk) begin
        if (accept) begin
            idx <= haddr[LB +: IW];
            wr <= hwrite;
            be_q <= be;
        end
    end

    always_ff @(posedge hclk) begin
        if (!reset && last && wr)
            for (int i = 0; i < NB; i++)
                if (be_q[i]) mem[idx][8*i +: 8] <= hwdata[8*i +: 8];
    end
endmodule

// File: tb/tb_ahb_slave_mem.sv
// tb_ahb_slave_mem: two slaves (0 and 3 wait states) on one shared bus,
// random traffic scored against a byte-level memory model.
module tb_ahb_slave_mem;
    logic        hclk = 1'b0, reset = 1'b1, hsel = 1'b0, hwrite = 1'b0, which = 1'b0, mon_en = 1'b0;
    logic [31:0] haddr = '0, hwdata = '0, rd0, rd1, hrdata;
    logic [1:0]  htrans = 2'b00, rs0, rs1, hresp;
    logic [2:0]  hsize = 3'd2;
    logic        ro0, ro1, hready;
    int          vectors = 0, miscompares = 0, cyc = 0, wt = 0;

    typedef struct {
        int          acyc;
        logic        err;
        int          waits;
        logic [31:0] rdata;
    } exp_t;
    exp_t        q[$];
    logic [31:0] model [2][16];

    always #5 hclk = ~hclk;
    always @(posedge hclk) cyc <= cyc + 1;

    assign hready = which ? ro1 : ro0;
    assign hresp  = which ? rs1 : rs0;
    assign hrdata = which ? rd1 : rd0;

    ahb_slave_mem #(.DATA_W(32), .DEPTH(256), .ADDR_W(32), .WAIT_STATES(0)) u0 (
        .hclk(hclk), .reset(reset), .hsel(hsel & ~which), .haddr(haddr), .htrans(htrans),
        .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata), .hready(hready),
        .hreadyout(ro0), .hresp(rs0), .hrdata(rd0)
    );
    ahb_slave_mem #(.DATA_W(32), .DEPTH(256), .ADDR_W(32), .WAIT_STATES(3)) u1 (
        .hclk(hclk), .reset(reset), .hsel(hsel & which), .haddr(haddr), .htrans(htrans),
        .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata), .hready(hready),
        .hreadyout(ro1), .hresp(rs1), .hrdata(rd1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (slave %0d, cycle %0d)", name, act, exp, which, cyc);
        end
    endtask

    task automatic expect_xfer(input logic wr, input logic [31:0] addr, input logic [2:0] sz, input logic [31:0] wd);
        exp_t e;
        int   n, w, lane;
        n = 1 << sz;
        w = int'(addr >> 2);
        e.acyc = cyc;
        e.err = (w >= 256) || (n > 4) || (addr % n != 0);
        e.waits = e.err ? 1 : (which ? 3 : 0);
        e.rdata = '0;
        if (!e.err) begin
            if (wr)
                for (int k = 0; k < n; k++) begin
                    lane = int'(addr % 4) + k;
                    model[which][w][8*lane +: 8] = wd[8*lane +: 8];
                end
            else
                e.rdata = model[which][w];
        end
        q.push_back(e);
    endtask

    // hold the address phase until the bus is ready, then present its write data
    task automatic issue(input logic sel, input logic [1:0] tr, input logic wr, input logic [31:0] addr,
                         input logic [2:0] sz, input logic [31:0] wd);
        logic acc = 1'b0;
        hsel = sel; htrans = tr; hwrite = wr; haddr = addr; hsize = sz;
        for (int n = 0; n < 20 && !acc; n++) begin
            @(negedge hclk);
            if (hready) begin
                acc = 1'b1;
                if (sel && tr[1]) expect_xfer(wr, addr, sz, wd);
            end
            @(posedge hclk);
            #1;
        end
        if (acc) hwdata = wd;
        else begin
            vectors++;
            miscompares++;
            $display("FAIL accept timeout: hready stayed 0 for 20 cycles (slave %0d)", which);
        end
    endtask

    task automatic chk_reset_outputs();
        chk("reset hreadyout", {31'd0, hready}, 32'd1);
        chk("reset hresp", {30'd0, hresp}, 32'd0);
        chk("reset hrdata", hrdata, 32'd0);
    endtask

    always @(negedge hclk) begin
        if (!mon_en) wt = 0;
        else if (q.size() > 0 && q[0].acyc < cyc) begin
            chk("hresp", {30'd0, hresp}, q[0].err ? 32'd1 : 32'd0);
            if (!hready) begin
                wt++;
                if (wt > 10) begin
                    chk("wait bound", wt, q[0].waits);
                    void'(q.pop_front());
                    wt = 0;
                end
            end else begin
                chk("wait cycles", wt, q[0].waits);
                chk("hrdata", hrdata, q[0].rdata);
                void'(q.pop_front());
                wt = 0;
            end
        end else begin
            chk("idle ready/resp", {29'd0, hready, hresp}, 32'h4);
            chk("idle hrdata", hrdata, 32'd0);
        end
    end

    initial begin
        #500000;
        $display("FAIL global timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] saved;
        logic        found;
        for (int w = 0; w < 2; w++) begin
            which = w[0];
            mon_en = 1'b0;
            q.delete();
            reset = 1'b1;
            hsel = 1'b0; htrans = 2'b00;
            repeat (2) @(posedge hclk);
            #1;
            @(negedge hclk);
            chk_reset_outputs();
            @(posedge hclk);
            #1;
            reset = 1'b0;
            mon_en = 1'b1;

            issue(1, 2'b10, 1, 32'h10, 2, 32'hDEADBEEF);
            issue(1, 2'b11, 0, 32'h10, 2, 32'h0);
            issue(1, 2'b10, 1, 32'h10, 2, 32'h11223344);
            issue(1, 2'b10, 1, 32'h13, 0, 32'hAAAAAAAA);
            issue(1, 2'b10, 0, 32'h10, 2, 32'h0);
            issue(1, 2'b10, 0, 32'h400, 2, 32'h0);
            issue(1, 2'b10, 0, 32'h01, 1, 32'h0);
            issue(1, 2'b10, 1, 32'h11, 1, 32'hFFFFFFFF);
            issue(1, 2'b10, 0, 32'h10, 2, 32'h0);

            for (int i = 0; i < 16; i++) issue(1, 2'b10, 1, 32'(i * 4), 2, $urandom);

            for (int t = 0; t < 250; t++) begin
                int          r;
                logic [2:0]  sz;
                logic [31:0] a;
                r = $urandom_range(0, 9);
                sz = ($urandom_range(0, 9) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
                a = ($urandom_range(0, 15) == 0) ? 32'h400 + 32'($urandom_range(0, 63)) : 32'($urandom_range(0, 63));
                if ($urandom_range(0, 3) != 0) a = a & ~((32'd1 << sz) - 32'd1);
                if (r == 0) issue(0, 2'b10, 1'($urandom_range(0, 1)), a, sz, $urandom);
                else if (r == 1) issue(1, 2'b01, 1'($urandom_range(0, 1)), a, sz, $urandom);
                else if (r == 2) issue(1, 2'b00, 1'($urandom_range(0, 1)), a, sz, $urandom);
                else issue(1, $urandom_range(0, 1) ? 2'b11 : 2'b10, 1'($urandom_range(0, 1)), a, sz, $urandom);
            end
            for (int i = 0; i < 16; i++) issue(1, 2'b11, 0, 32'(i * 4), 2, 32'h0);

            issue(1, 2'b10, 1, 32'h20, 2, 32'hCAFE0001);
            saved = model[which][8];
            issue(1, 2'b10, 1, 32'h20, 2, 32'h5555AAAA);
            mon_en = 1'b0;
            hsel = 1'b0; htrans = 2'b00;
            found = 1'b0;
            for (int n = 0; n < 10 && !found; n++) begin
                @(negedge hclk);
                if (hready) found = 1'b1;
                else @(posedge hclk);
            end
            chk("final write cycle reached", {31'd0, found}, 32'd1);
            reset = 1'b1;
            @(posedge hclk);
            #1;
            @(negedge hclk);
            chk_reset_outputs();
            @(posedge hclk);
            #1;
            reset = 1'b0;
            model[which][8] = saved;
            q.delete();
            mon_en = 1'b1;
            issue(1, 2'b10, 0, 32'h20, 2, 32'h0);
            issue(1, 2'b00, 0, 32'h0, 2, 32'h0);
            issue(1, 2'b00, 0, 32'h0, 2, 32'h0);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
